// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard-control bus: decode-side hazard info in, stage control out.
// The master side is the decoder/datapath; the slave side is pipe_hazard_ctrl.
// Optional debug single-step inputs exist only when PIPE_DEBUG_STEP_EN is defined.
// Handshake: there is no valid/ready pair; every output is meaningful on every
// cycle. The ID fields are sampled on each rising clk edge and qualified by
// stage_valid[1] inside the controller. redirect is a 1-cycle pulse.
interface pipe_hazard_ctrl_if #(
  parameter int STAGES = 5,
  parameter int REG_AW = 5
);
  localparam int FWD_W = $clog2(STAGES);

`ifdef PIPE_DEBUG_STEP_EN
  logic              debug_en;
  logic              debug_step;
`endif
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_wen;
  logic [REG_AW-1:0] id_waddr;
  logic              id_is_load;
  logic              redirect;
  logic              stall;
  logic [FWD_W-1:0]  fwd_a;
  logic [FWD_W-1:0]  fwd_b;
  logic [STAGES-1:0] stage_en;
  logic [STAGES-1:0] stage_flush;
  logic [STAGES-1:0] stage_valid;
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  modport master (
`ifdef PIPE_DEBUG_STEP_EN
    output debug_en, debug_step,
`endif
    output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
    output id_wen, id_waddr, id_is_load, redirect,
    input  stall, fwd_a, fwd_b, stage_en, stage_flush, stage_valid,
    input  stall_cnt, flush_cnt
  );

  modport slave (
`ifdef PIPE_DEBUG_STEP_EN
    input  debug_en, debug_step,
`endif
    input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
    input  id_wen, id_waddr, id_is_load, redirect,
    output stall, fwd_a, fwd_b, stage_en, stage_flush, stage_valid,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stage-control unit for the in-order MIPS pipeline.
// Stage 0=IF, 1=ID, STAGES-1=WB. A shift scoreboard tracks the destination
// register of every post-decode stage (2..STAGES-1) and drives ID forwarding
// selects, load-use stalls and branch-redirect flushes.
// Legal parameters: STAGES 4..8, 2 < LOAD_READY_STAGE < STAGES,
// BR_STAGE 1..STAGES-2.
// Optional macro PIPE_DEBUG_STEP_EN adds debug_en/debug_step single stepping.
module pipe_hazard_ctrl #(
  parameter int STAGES           = 5,
  parameter int REG_AW           = 5,
  parameter int LOAD_READY_STAGE = 3,
  parameter int BR_STAGE         = 2,
  parameter int FWD_W            = $clog2(STAGES)
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);

  typedef struct packed {
    logic              valid;
    logic              wen;
    logic [REG_AW-1:0] waddr;
    logic              load;
  } sb_entry_t;

  sb_entry_t         sb [2:STAGES-1];
  logic [STAGES-1:0] valid_q;
  logic [15:0]       stall_cnt_q;
  logic [15:0]       flush_cnt_q;

  logic              found_a, found_b;
  logic              load_a, load_b;
  logic [FWD_W-1:0]  sel_a, sel_b;
  logic              hz_a, hz_b;
  logic              stall_w;
  logic              stall_eff;
  logic              redir_eff;
  logic              squash_id;
  logic              advance;
  logic [STAGES-1:0] en_w;
  logic [STAGES-1:0] flush_w;
  sb_entry_t         id_entry;

`ifdef PIPE_DEBUG_STEP_EN
  logic [2:0] step_sync;
  logic       step_go;

  // Synchronise debug_step, detect its rising edge, and release one step the cycle after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_sync <= '0;
      step_go   <= 1'b0;
    end else begin
      step_sync <= {step_sync[1:0], bus.debug_step};
      step_go   <= step_sync[1] & ~step_sync[2];
    end
  end

  assign advance = ~bus.debug_en | step_go;
`else
  assign advance = 1'b1;
`endif

  // Forwarding lookup: scan oldest to youngest so the lowest matching stage wins.
  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    load_a  = 1'b0;
    load_b  = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    for (int k = STAGES - 1; k >= 2; k--) begin
      if (sb[k].valid && sb[k].wen && (sb[k].waddr != '0) &&
          (sb[k].waddr == bus.id_rs_addr)) begin
        found_a = 1'b1;
        sel_a   = FWD_W'(k);
        load_a  = sb[k].load;
      end
      if (sb[k].valid && sb[k].wen && (sb[k].waddr != '0) &&
          (sb[k].waddr == bus.id_rt_addr)) begin
        found_b = 1'b1;
        sel_b   = FWD_W'(k);
        load_b  = sb[k].load;
      end
    end
  end

  // A load still short of its data-ready stage cannot feed ID; redirect overrides the stall.
  assign hz_a      = bus.id_rs_used & found_a & load_a & (sel_a < FWD_W'(LOAD_READY_STAGE));
  assign hz_b      = bus.id_rt_used & found_b & load_b & (sel_b < FWD_W'(LOAD_READY_STAGE));
  assign stall_w   = (hz_a | hz_b) & ~bus.redirect;
  assign stall_eff = stall_w & advance;
  assign redir_eff = bus.redirect & advance;
  assign squash_id = bus.redirect && (BR_STAGE >= 2);
  assign id_entry  = {1'b1, bus.id_wen, bus.id_waddr, bus.id_is_load};

  // Stage enables and flushes: stall holds IF/ID and bubbles stage 2; redirect clears stages younger than the branch.
  always_comb begin
    en_w    = '1;
    flush_w = '0;
    if (stall_eff) begin
      en_w[1:0]  = 2'b00;
      flush_w[2] = 1'b1;
    end
    if (redir_eff) begin
      for (int i = 1; i < BR_STAGE; i++) begin
        flush_w[i] = 1'b1;
      end
    end
    if (!advance) begin
      en_w    = '0;
      flush_w = '0;
    end
  end

  // Per-stage valid bits: flush clears, enable shifts from the previous stage, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      if (flush_w[0]) valid_q[0] <= 1'b0;
      else if (en_w[0]) valid_q[0] <= 1'b1;
      for (int i = 1; i < STAGES; i++) begin
        if (flush_w[i]) valid_q[i] <= 1'b0;
        else if (en_w[i]) valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Scoreboard shift: older entries always move on; stage 2 takes ID or a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 2; k < STAGES; k++) begin
        sb[k] <= '0;
      end
    end else if (advance) begin
      if (valid_q[1] && !stall_w && !squash_id) sb[2] <= id_entry;
      else sb[2] <= '0;
      for (int k = 3; k < STAGES; k++) begin
        sb[k] <= sb[k-1];
      end
    end
  end

  // Saturating event counters for stall cycles and redirect events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_eff && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (redir_eff && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.stall       = stall_w;
  assign bus.fwd_a       = (found_a && bus.id_rs_used) ? sel_a : '0;
  assign bus.fwd_b       = (found_b && bus.id_rt_used) ? sel_b : '0;
  assign bus.stage_en    = en_w;
  assign bus.stage_flush = flush_w;
  assign bus.stage_valid = valid_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule
